// File: rtl/seg7_reader_if.sv
// Segment-bus and frame-handshake bundle shared by the display driver and seg7_reader.
interface seg7_reader_if;
    logic [6:0]  seg7_0;
    logic [6:0]  seg7_1;
    logic [6:0]  seg7_2;
    logic [6:0]  seg7_3;
    logic [6:0]  seg7_4;
    logic [6:0]  seg7_5;
    logic [23:0] value;
    logic [5:0]  err;
    logic [5:0]  blank;
    logic        valid;
    logic        ready;
    logic        overflow;

    modport master (
        output seg7_0, seg7_1, seg7_2, seg7_3, seg7_4, seg7_5, ready,
        input  value, err, blank, valid, overflow
    );

    modport slave (
        input  seg7_0, seg7_1, seg7_2, seg7_3, seg7_4, seg7_5, ready,
        output value, err, blank, valid, overflow
    );
endinterface

// File: rtl/seg7_reader.sv
// Waits for a stable six-digit seven-segment display, decodes it and queues frames in a 2-deep buffer.
// Optional feature macro: SEG7_READER_BLANK_EN (7'h7F decodes as blank instead of error).
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          nreset,
    seg7_reader_if.slave  bus
);
    localparam logic [7:0]  CNT_TOP  = 8'(STABLE_CYCLES);
    localparam logic [7:0]  CNT_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [41:0] ALL_DARK = {6{7'h7F}};

    // Returns {err, blank, nibble} for one active-low digit pattern.
    function automatic logic [5:0] decode_digit(input logic [6:0] seg);
        logic [5:0] res;
        case (seg)
            7'h40:   res = 6'h00;
            7'h79:   res = 6'h01;
            7'h24:   res = 6'h02;
            7'h30:   res = 6'h03;
            7'h19:   res = 6'h04;
            7'h12:   res = 6'h05;
            7'h02:   res = 6'h06;
            7'h78:   res = 6'h07;
            7'h00:   res = 6'h08;
            7'h10:   res = 6'h09;
            7'h08:   res = 6'h0A;
            7'h03:   res = 6'h0B;
            7'h46:   res = 6'h0C;
            7'h21:   res = 6'h0D;
            7'h06:   res = 6'h0E;
            7'h0E:   res = 6'h0F;
`ifdef SEG7_READER_BLANK_EN
            7'h7F:   res = 6'b01_0000;
`endif
            default: res = 6'b10_0000;
        endcase
        return res;
    endfunction

    logic [41:0] w_in;
    logic        w_same;
    logic        w_accept;
    logic        w_pop;
    logic [5:0]  w_dec [6];
    logic [35:0] w_frame;

    logic [41:0] r_s;
    logic [41:0] r_last;
    logic        r_first;
    logic [7:0]  r_cnt;
    logic [35:0] r_head;
    logic [35:0] r_tail;
    logic [1:0]  r_count;
    logic        r_overflow;

    assign w_in   = {bus.seg7_5, bus.seg7_4, bus.seg7_3, bus.seg7_2, bus.seg7_1, bus.seg7_0};
    assign w_same = (w_in == r_s);
    // The count reaches its top on this edge; suppress only a repeat of the last reported display.
    assign w_accept = w_same && (r_cnt == CNT_LAST) && ((r_s != r_last) || r_first);
    assign w_pop    = (r_count != 2'd0) && bus.ready;

    // Decode each digit of the held sample.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            w_dec[i] = decode_digit(r_s[7*i +: 7]);
        end
    end

    // Pack decoded digits into a {value, err, blank} frame.
    always_comb begin
        w_frame = 36'd0;
        for (int i = 0; i < 6; i++) begin
            w_frame[12 + 4*i +: 4] = w_dec[i][3:0];
            w_frame[6 + i]         = w_dec[i][5];
            w_frame[i]             = w_dec[i][4];
        end
    end

    // Sample register, stability counter and duplicate-suppression state.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_s     <= ALL_DARK;
            r_last  <= ALL_DARK;
            r_first <= 1'b1;
            r_cnt   <= 8'd0;
        end else begin
            r_s <= w_in;
            if (!w_same) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != CNT_TOP) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_accept) begin
                r_last  <= r_s;
                r_first <= 1'b0;
            end else begin
                r_last  <= r_last;
                r_first <= r_first;
            end
        end
    end

    // Two-entry frame buffer; the head register drives the outputs directly.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_head     <= 36'd0;
            r_tail     <= 36'd0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
        end else if (w_pop) begin
            if (r_count == 2'd2) begin
                r_head <= w_accept ? r_tail : r_tail;
            end else begin
                r_head <= w_accept ? w_frame : r_head;
            end
            if (w_accept && (r_count == 2'd2)) begin
                r_tail <= w_frame;
            end else begin
                r_tail <= r_tail;
            end
            r_count <= w_accept ? r_count : (r_count - 2'd1);
        end else if (w_accept) begin
            case (r_count)
                2'd0: begin
                    r_head  <= w_frame;
                    r_count <= 2'd1;
                end
                2'd1: begin
                    r_tail  <= w_frame;
                    r_count <= 2'd2;
                end
                default: r_overflow <= 1'b1;
            endcase
        end else begin
            r_count <= r_count;
        end
    end

    assign bus.value    = r_head[35:12];
    assign bus.err      = r_head[11:6];
    assign bus.blank    = r_head[5:0];
    assign bus.valid    = (r_count != 2'd0);
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader: frame table, latency, toggling, overflow and async reset sequences.
module tb_seg7_reader;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    seg7_reader_if bif ();

    seg7_reader #(.STABLE_CYCLES(4)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [41:0] disp;
        logic        has_frame;
        logic [23:0] val;
        logic [5:0]  err;
        logic [5:0]  blk;
    } vec_t;

    vec_t        vecs [8];
    logic [35:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [41:0] mk(input logic [6:0] d5, input logic [6:0] d4, input logic [6:0] d3,
                                       input logic [6:0] d2, input logic [6:0] d1, input logic [6:0] d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_disp(input logic [41:0] d);
        bif.seg7_0 = d[6:0];
        bif.seg7_1 = d[13:7];
        bif.seg7_2 = d[20:14];
        bif.seg7_3 = d[27:21];
        bif.seg7_4 = d[34:28];
        bif.seg7_5 = d[41:35];
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake must match the oldest expected frame.
    always @(negedge clk) begin
        if (bif.valid && bif.ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame: got %0h expected none", {bif.value, bif.err, bif.blank});
            end else begin
                check("frame", 64'({bif.value, bif.err, bif.blank}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        logic [41:0] a_d, b_d, c_d, d_d, e_d;

        vecs[0] = '{mk(7'h40,7'h40,7'h40,7'h40,7'h40,7'h40), 1'b1, 24'h000000, 6'b0, 6'b0};
        vecs[1] = '{mk(7'h79,7'h24,7'h30,7'h08,7'h03,7'h0E), 1'b1, 24'h123ABF, 6'b0, 6'b0};
        vecs[2] = '{mk(7'h40,7'h40,7'h55,7'h40,7'h40,7'h40), 1'b1, 24'h000000, 6'b001000, 6'b0};
`ifdef SEG7_READER_BLANK_EN
        vecs[3] = '{mk(7'h40,7'h40,7'h7F,7'h40,7'h40,7'h40), 1'b1, 24'h000000, 6'b0, 6'b001000};
`else
        vecs[3] = '{mk(7'h40,7'h40,7'h7F,7'h40,7'h40,7'h40), 1'b1, 24'h000000, 6'b001000, 6'b0};
`endif
        vecs[4] = '{mk(7'h19,7'h12,7'h02,7'h78,7'h00,7'h10), 1'b1, 24'h456789, 6'b0, 6'b0};
        vecs[5] = '{mk(7'h46,7'h21,7'h06,7'h40,7'h40,7'h40), 1'b1, 24'hCDE000, 6'b0, 6'b0};
        vecs[6] = '{mk(7'h46,7'h21,7'h06,7'h40,7'h40,7'h40), 1'b0, 24'hCDE000, 6'b0, 6'b0};
        vecs[7] = '{mk(7'h40,7'h40,7'h40,7'h40,7'h40,7'h40), 1'b1, 24'h000000, 6'b0, 6'b0};

        // Reset state and first-frame latency.
        set_disp(vecs[0].disp);
        bif.ready = 1'b1;
        cycles(2);
        check("reset_valid", 64'(bif.valid), 64'd0);
        check("reset_overflow", 64'(bif.overflow), 64'd0);
        check("reset_value", 64'(bif.value), 64'd0);
        exp_q.push_back({24'h000000, 6'b0, 6'b0});
        nreset = 1'b1;
        edges = 0;
        while (!bif.valid && edges < 20) begin
            cycles(1);
            edges++;
        end
        check("latency", 64'(edges - 1), 64'd4);
        cycles(10);

        for (int i = 1; i < 8; i++) begin
            set_disp(vecs[i].disp);
            if (vecs[i].has_frame) begin
                exp_q.push_back({vecs[i].val, vecs[i].err, vecs[i].blk});
            end
            cycles(10);
        end
        check("table_drained", 64'(exp_q.size()), 64'd0);

        // Digit 0 toggles faster than the stability window, then settles on 2.
        exp_q.push_back({24'h000002, 6'b0, 6'b0});
        for (int i = 0; i < 10; i++) begin
            set_disp(mk(7'h40,7'h40,7'h40,7'h40,7'h40, (i % 2 == 0) ? 7'h79 : 7'h24));
            cycles(2);
        end
        cycles(10);
        check("toggle_drained", 64'(exp_q.size()), 64'd0);

        // Back-pressure: three stable displays into a 2-entry buffer.
        a_d = {6{7'h79}};
        b_d = {6{7'h24}};
        c_d = {6{7'h30}};
        bif.ready = 1'b0;
        set_disp(a_d);
        cycles(10);
        set_disp(b_d);
        cycles(10);
        check("ovf_before_third", 64'(bif.overflow), 64'd0);
        set_disp(c_d);
        cycles(10);
        check("ovf_valid", 64'(bif.valid), 64'd1);
        check("ovf_head", 64'(bif.value), 64'h111111);
        check("ovf_flag", 64'(bif.overflow), 64'd1);
        exp_q.push_back({24'h111111, 6'b0, 6'b0});
        exp_q.push_back({24'h222222, 6'b0, 6'b0});
        bif.ready = 1'b1;
        cycles(12);
        check("ovf_drained", 64'(exp_q.size()), 64'd0);
        check("ovf_sticky", 64'(bif.overflow), 64'd1);

        // Asynchronous reset with two frames buffered.
        d_d = {6{7'h19}};
        e_d = {6{7'h12}};
        bif.ready = 1'b0;
        set_disp(d_d);
        cycles(10);
        set_disp(e_d);
        cycles(10);
        check("pre_rst_valid", 64'(bif.valid), 64'd1);
        #1;
        nreset = 1'b0;
        #1;
        check("arst_valid", 64'(bif.valid), 64'd0);
        check("arst_overflow", 64'(bif.overflow), 64'd0);
        check("arst_outputs", 64'({bif.value, bif.err, bif.blank}), 64'd0);
        cycles(1);
        nreset = 1'b1;
        exp_q.push_back({24'h555555, 6'b0, 6'b0});
        bif.ready = 1'b1;
        cycles(15);
        check("post_rst_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
